muldiv_sched: RTL and testbench

- Issue/sequencing controller for the multi-cycle M-extension operations the decoder tags as op_mode 5 (MUL), 6 (DIV) and 7 (REM).
- Sits between decode/register-read and a shared iterative mul/div unit.
- Accepts one operation at a time, launches the unit, and counts the fixed latency while holding the front-end stalled.
- Captures the result and hands it to write-back with a valid/ready handshake.

---
 rtl/muldiv_sched.sv | 242 ++++++++++++++++++++++++
 tb/tb_muldiv_sched.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// -----------------------------------------------------------------------------
// muldiv_sched
//
// Issue and sequencing controller for the multi-cycle M-extension operations
// (decoder op_mode 5 = MUL, 6 = DIV, 7 = REM). It accepts one operation at a
// time, launches the shared iterative mul/div unit, counts that unit's fixed
// latency while the front-end is stalled, captures the result and hands it to
// write-back with a valid/ready handshake.
//
// Parameters
//   MUL_LAT  cycles from o_unit_start to a valid i_unit_result for MUL (>=1)
//   DIV_LAT  cycles from o_unit_start to a valid i_unit_result for DIV/REM (>=1)
//   CNT_W    latency counter width, holds max(MUL_LAT, DIV_LAT)-1
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), asynchronous active-low reset
//   i_valid, i_op_mode    decoded instruction and its op_mode
//   i_rd, i_rs1_val,
//   i_rs2_val             destination register and the two operands
//   i_flush               pipeline flush (branch redirect)
//   o_stall               holds decode/fetch while an op is in flight
//   o_unit_start          one-cycle launch pulse to the unit
//   o_unit_op             0 = MUL, 1 = DIV, 2 = REM
//   o_unit_a, o_unit_b    registered operands to the unit
//   i_unit_result         unit result, sampled on the last BUSY cycle
//   o_wb_valid, o_wb_rd,
//   o_wb_data, i_wb_ready write-back handshake
//   o_pend_valid,
//   o_pend_rd             in-flight op indication for hazard checks
// -----------------------------------------------------------------------------
module muldiv_sched #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [2:0]  i_op_mode,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_rs1_val,
    input  logic [31:0] i_rs2_val,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_unit_start,
    output logic [1:0]  o_unit_op,
    output logic [31:0] o_unit_a,
    output logic [31:0] o_unit_b,
    input  logic [31:0] i_unit_result,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    input  logic        i_wb_ready,
    output logic        o_pend_valid,
    output logic [4:0]  o_pend_rd
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Counter load values: the counter reaches 0 on the cycle the result is valid.
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_LAT - 1);

    // True for the op_modes this block owns.
    function automatic logic f_is_muldiv(input logic [2:0] op_mode);
        logic ok;
        case (op_mode)
            3'd5, 3'd6, 3'd7: ok = 1'b1;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Maps decoder op_mode to the unit's op encoding.
    function automatic logic [1:0] f_unit_op(input logic [2:0] op_mode);
        logic [1:0] op;
        case (op_mode)
            3'd5:    op = 2'd0;
            3'd6:    op = 2'd1;
            3'd7:    op = 2'd2;
            default: op = 2'd0;
        endcase
        return op;
    endfunction

    // Counter start value for the selected op.
    function automatic logic [CNT_W-1:0] f_cnt_load(input logic [2:0] op_mode);
        logic [CNT_W-1:0] v;
        case (op_mode)
            3'd5:       v = MUL_LAST;
            3'd6, 3'd7: v = DIV_LAST;
            default:    v = MUL_LAST;
        endcase
        return v;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start;
    logic [1:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [4:0]       r_rd;
    logic [4:0]       r_pend_rd;
    logic [31:0]      r_result;
    logic             r_wb_valid;
    logic             r_stall;

    state_t           w_state;
    logic [CNT_W-1:0] w_cnt;
    logic             w_start;
    logic [1:0]       w_op;
    logic [31:0]      w_a;
    logic [31:0]      w_b;
    logic [4:0]       w_rd;
    logic [4:0]       w_pend_rd;
    logic [31:0]      w_result;
    logic             w_wb_valid;
    logic             w_stall;

    // Next-state and next-register values for the IDLE/BUSY/WB sequencer.
    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_start    = 1'b0;
        w_op       = r_op;
        w_a        = r_a;
        w_b        = r_b;
        w_rd       = r_rd;
        w_pend_rd  = r_pend_rd;
        w_result   = r_result;
        w_wb_valid = r_wb_valid;
        w_stall    = r_stall;

        case (r_state)
            ST_IDLE: begin
                // A flush in the acceptance cycle kills the candidate instruction.
                if (i_valid && f_is_muldiv(i_op_mode) && !i_flush) begin
                    w_state   = ST_BUSY;
                    w_cnt     = f_cnt_load(i_op_mode);
                    w_start   = 1'b1;
                    w_op      = f_unit_op(i_op_mode);
                    w_a       = i_rs1_val;
                    w_b       = i_rs2_val;
                    w_rd      = i_rd;
                    w_pend_rd = i_rd;
                    w_stall   = 1'b1;
                end else begin
                    w_state   = ST_IDLE;
                end
            end

            ST_BUSY: begin
                if (i_flush) begin
                    // The unit keeps running; its late result is simply never sampled.
                    w_state   = ST_IDLE;
                    w_cnt     = '0;
                    w_pend_rd = 5'd0;
                    w_stall   = 1'b0;
                end else if (r_cnt == '0) begin
                    w_result = i_unit_result;
                    if (r_rd != 5'd0) begin
                        w_state    = ST_WB;
                        w_wb_valid = 1'b1;
                    end else begin
                        // x0 destination: nothing to write back.
                        w_state   = ST_IDLE;
                        w_pend_rd = 5'd0;
                        w_stall   = 1'b0;
                    end
                end else begin
                    w_cnt = r_cnt - CNT_W'(1);
                end
            end

            ST_WB: begin
                // The op is committed here, so flush has no effect.
                if (i_wb_ready) begin
                    w_state    = ST_IDLE;
                    w_wb_valid = 1'b0;
                    w_pend_rd  = 5'd0;
                    w_stall    = 1'b0;
                end else begin
                    w_state    = ST_WB;
                end
            end

            default: begin
                w_state    = ST_IDLE;
                w_cnt      = '0;
                w_pend_rd  = 5'd0;
                w_wb_valid = 1'b0;
                w_stall    = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_start    <= 1'b0;
            r_op       <= 2'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_rd       <= 5'd0;
            r_pend_rd  <= 5'd0;
            r_result   <= 32'd0;
            r_wb_valid <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_start    <= w_start;
            r_op       <= w_op;
            r_a        <= w_a;
            r_b        <= w_b;
            r_rd       <= w_rd;
            r_pend_rd  <= w_pend_rd;
            r_result   <= w_result;
            r_wb_valid <= w_wb_valid;
            r_stall    <= w_stall;
        end
    end

    assign o_stall      = r_stall;
    assign o_unit_start = r_start;
    assign o_unit_op    = r_op;
    assign o_unit_a     = r_a;
    assign o_unit_b     = r_b;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_rd      = r_rd;
    assign o_wb_data    = r_result;
    assign o_pend_valid = (r_state != ST_IDLE);
    assign o_pend_rd    = r_pend_rd;

endmodule

// File: tb/tb_muldiv_sched.sv
module tb_muldiv_sched;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 33;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [2:0]  i_op_mode;
    logic [4:0]  i_rd;
    logic [31:0] i_rs1_val;
    logic [31:0] i_rs2_val;
    logic        i_flush;
    logic        o_stall;
    logic        o_unit_start;
    logic [1:0]  o_unit_op;
    logic [31:0] o_unit_a;
    logic [31:0] o_unit_b;
    logic [31:0] i_unit_result;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        i_wb_ready;
    logic        o_pend_valid;
    logic [4:0]  o_pend_rd;

    muldiv_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_op_mode(i_op_mode),
        .i_rd(i_rd), .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val), .i_flush(i_flush),
        .o_stall(o_stall), .o_unit_start(o_unit_start), .o_unit_op(o_unit_op),
        .o_unit_a(o_unit_a), .o_unit_b(o_unit_b), .i_unit_result(i_unit_result),
        .o_wb_valid(o_wb_valid), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .i_wb_ready(i_wb_ready), .o_pend_valid(o_pend_valid), .o_pend_rd(o_pend_rd)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wb_delay = 0;
    int   wbcnt = 0;
    int   ucnt = 0;
    int   ulat = 0;
    logic prev_wbv = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Behavioural result of the external unit: unit op 0=MUL,1=DIV,2=REM.
    function automatic logic [31:0] ref_fn(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            2'd1: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'd2: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Unit model: result valid only on unit cycle LAT (start cycle = 1), junk otherwise.
    always @(posedge clk) begin
        #1;
        if (o_unit_start) begin
            ucnt = 1;
            ulat = (o_unit_op == 2'd0) ? MUL_LAT : DIV_LAT;
        end else if (ucnt != 0) begin
            ucnt++;
        end
        if (ucnt != 0 && ucnt == ulat) i_unit_result = ref_fn(o_unit_op, o_unit_a, o_unit_b);
        else                           i_unit_result = $urandom;
    end

    // Write-back sink: ready after wb_delay WB cycles; random noise outside WB.
    always @(posedge clk) begin
        #1;
        if (o_wb_valid) begin
            i_wb_ready = (wbcnt >= wb_delay);
            wbcnt++;
        end else begin
            wbcnt = 0;
            i_wb_ready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && o_wb_valid) begin
            if (sb_q.size() == 0) begin
                chk("wb_unexpected", {31'd0, o_wb_valid}, 32'd0);
            end else begin
                chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, sb_q[0].rd});
                chk("wb_data", o_wb_data, sb_q[0].data);
                if (!prev_wbv) chk("wb_latency", cyc - sb_q[0].acc, sb_q[0].lat + 1);
                if (i_wb_ready) void'(sb_q.pop_front());
            end
        end
        prev_wbv = o_wb_valid;
    end

    task automatic check_zero(input string nm);
        chk({nm, "_stall"}, {31'd0, o_stall}, 32'd0);
        chk({nm, "_outs"},
            {31'd0, |{o_unit_start, o_unit_op, o_unit_a, o_unit_b, o_wb_valid,
                      o_wb_rd, o_wb_data, o_pend_valid, o_pend_rd}}, 32'd0);
    endtask

    // kill: 0 none, 1 flush on BUSY cycle kat, 2 async reset during BUSY cycle kat.
    task automatic issue(input logic [2:0] om, input logic [4:0] rdv, input logic [31:0] av,
                         input logic [31:0] bv, input int kill, input int kat, input int rdly);
        int lat;
        int k;
        int stall_n;
        int starts;
        int guard;
        exp_t e;
        lat = (om == 3'd5) ? MUL_LAT : DIV_LAT;
        wb_delay  = rdly;
        i_valid   = 1'b1;
        i_op_mode = om;
        i_rd      = rdv;
        i_rs1_val = av;
        i_rs2_val = bv;
        if (kill == 0 && rdv != 5'd0) begin
            e.rd = rdv; e.data = ref_fn(2'(om - 3'd5), av, bv); e.acc = cyc; e.lat = lat;
            sb_q.push_back(e);
        end
        @(negedge clk);
        i_valid   = 1'b0;
        i_rd      = 5'($urandom);
        i_rs1_val = $urandom;
        i_rs2_val = $urandom;
        chk("start_pulse", {31'd0, o_unit_start}, 32'd1);
        chk("unit_op", {30'd0, o_unit_op}, {30'd0, 2'(om - 3'd5)});
        chk("unit_a", o_unit_a, av);
        chk("unit_b", o_unit_b, bv);
        chk("busy_stall", {31'd0, o_stall}, 32'd1);
        chk("pend_valid", {31'd0, o_pend_valid}, 32'd1);
        chk("pend_rd", {27'd0, o_pend_rd}, {27'd0, rdv});
        if (kill != 0) begin
            k = 1;
            while (k < kat) begin @(negedge clk); k++; end
            if (kill == 1) begin
                i_flush = 1'b1;
                @(negedge clk);
                i_flush = 1'b0;
                chk("flush_stall", {31'd0, o_stall}, 32'd0);
                chk("flush_pend", {31'd0, o_pend_valid}, 32'd0);
                chk("flush_wbv", {31'd0, o_wb_valid}, 32'd0);
            end else begin
                #2 rst_n = 1'b0;
                #1 check_zero("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
        end else begin
            stall_n = 1; starts = 1; guard = 0;
            forever begin
                @(negedge clk);
                guard++;
                if (!o_stall || guard > 500) break;
                stall_n++;
                if (o_unit_start) starts++;
            end
            chk("stall_len", stall_n, (rdv != 5'd0) ? lat + rdly + 1 : lat);
            chk("start_count", starts, 32'd1);
            chk("idle_pend", {31'd0, o_pend_valid}, 32'd0);
            chk("idle_pend_rd", {27'd0, o_pend_rd}, 32'd0);
            chk("idle_wbv", {31'd0, o_wb_valid}, 32'd0);
            chk("sb_drained", sb_q.size(), 32'd0);
        end
    endtask

    task automatic ignored(input logic [2:0] om, input logic fl);
        i_valid = 1'b1; i_op_mode = om; i_flush = fl;
        i_rd = 5'd3; i_rs1_val = 32'd1; i_rs2_val = 32'd2;
        @(negedge clk);
        i_valid = 1'b0; i_flush = 1'b0;
        chk("ign_start", {31'd0, o_unit_start}, 32'd0);
        chk("ign_stall", {31'd0, o_stall}, 32'd0);
        chk("ign_pend", {31'd0, o_pend_valid}, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_op_mode = 3'd0; i_rd = 5'd0;
        i_rs1_val = 32'd0; i_rs2_val = 32'd0; i_flush = 1'b0;
        i_unit_result = 32'd0; i_wb_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(3'd5, 5'd5, 32'd7, 32'd6, 0, 0, 0);        // MUL 7*6
        issue(3'd6, 5'd9, 32'd100, 32'd7, 0, 0, 0);      // DIV 100/7
        issue(3'd7, 5'd3, 32'd100, 32'd7, 0, 0, 5);      // REM, ready held 5 WB cycles
        issue(3'd6, 5'd12, 32'd1000, 32'd3, 1, 10, 0);   // DIV flushed on BUSY cycle 10
        issue(3'd5, 5'd4, 32'd11, 32'd13, 0, 0, 0);      // accepted right after flush
        issue(3'd5, 5'd0, 32'd3, 32'd4, 0, 0, 0);        // rd=0, no write-back
        ignored(3'd4, 1'b0);
        ignored(3'd5, 1'b1);
        ignored(3'd7, 1'b1);
        issue(3'd5, 5'd7, 32'd2, 32'd3, 2, 2, 0);        // async reset mid-BUSY
        issue(3'd5, 5'd8, 32'd9, 32'd9, 0, 0, 0);

        for (int n = 0; n < 20; n++) begin
            issue(3'(5 + $urandom_range(0, 2)), 5'($urandom), $urandom,
                  (($urandom_range(0, 7) == 0) ? 32'd0 : $urandom), 0, 0,
                  int'($urandom_range(0, 3)));
        end

        chk("final_sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
